// File: rtl/btn_debounce_pulse.sv
// Debounces a raw asynchronous button input. The input is synchronised first.
// A new level is accepted only after STABLE_CYCLES identical samples in a row.
// The block gives a registered level and one-cycle rise/fall pulses.
module btn_debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic bouncing
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_L2H  = 2'd1,
        S_HIGH = 2'd2,
        S_H2L  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   bouncing_q, bouncing_d;
    logic                   s;

    // The FSM looks only at the last synchroniser stage.
    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    // Next-state logic. The counter holds the number of agreeing samples seen.
    // The counter restarts on every state entry and stops at CNT_LAST, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_L2H;
                    cnt_d   = CW'(1);
                end
            end
            S_L2H: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_H2L;
                    cnt_d   = CW'(1);
                end
            end
            S_H2L: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
        // Decode from the next state so the flop matches the state register.
        bouncing_d = (state_d == S_L2H) || (state_d == S_H2L);
    end

    // State and output registers. Reset wins over any transition or pulse in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= S_LOW;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            bouncing_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            bouncing_q <= bouncing_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign bouncing   = bouncing_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse. A run-length reference model
// pushes the expected outputs for each edge. A monitor pops and compares them.
module tb_btn_debounce_pulse;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b1;
    logic level, rise_pulse, fall_pulse, bouncing;

    btn_debounce_pulse #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .level     (level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .bouncing  (bouncing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic bouncing;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_rise_cyc = -1000;
    int   last_pulse_cyc = -1000;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic [1:0] cnt2;

    // Reference model. s is btn_in delayed by SYNC_STAGES edges.
    // Level flips after STABLE_CYCLES consecutive samples that differ from it.
    bit m_level;
    int m_run;
    bit hist[$];
    always @(posedge clk) begin
        exp_t e;
        bit   s;
        cyc++;
        e = '0;
        if (rst) begin
            m_level = 0;
            m_run   = 0;
            hist    = {};
            for (int i = 0; i < SYNC_STAGES; i++) hist.push_front(1'b0);
        end else begin
            s = hist[SYNC_STAGES-1];
            hist.push_front(btn_in);
            void'(hist.pop_back());
            if (s != m_level) begin
                m_run++;
                if (m_run == STABLE_CYCLES) begin
                    m_level = s;
                    m_run   = 0;
                    e.rise  = s;
                    e.fall  = !s;
                end
            end else begin
                m_run = 0;
            end
            e.level    = m_level;
            e.bouncing = (m_run > 0);
        end
        sb.push_back(e);
    end

    // Downstream 2-bit counter that uses rise_pulse as its step request.
    always @(posedge clk) begin
        if (rst) cnt2 <= 2'b00;
        else if (rise_pulse) cnt2 <= cnt2 + 2'b01;
    end

    // Monitor that compares the DUT outputs with the scoreboard after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty cyc=%0d", cyc);
        end else begin
            e = sb.pop_front();
            if ({level, rise_pulse, fall_pulse, bouncing} !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got lvl/rise/fall/bnc=%b%b%b%b want %b%b%b%b",
                         cyc, level, rise_pulse, fall_pulse, bouncing,
                         e.level, e.rise, e.fall, e.bouncing);
            end
        end
        if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
            checks++;
            if (rise_pulse && fall_pulse) begin
                errors++;
                $display("FAIL both_pulses cyc=%0d got rise=1 fall=1 want not both", cyc);
            end
            checks++;
            if (cyc - last_pulse_cyc < STABLE_CYCLES) begin
                errors++;
                $display("FAIL pulse_gap cyc=%0d got gap %0d want >=%0d",
                         cyc, cyc - last_pulse_cyc, STABLE_CYCLES);
            end
            last_pulse_cyc = cyc;
            if (rise_pulse) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            if (fall_pulse) fall_cnt++;
        end
    end

    task automatic step(input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_in = b;
            rst    = r;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int t0, r0, f0;
        // 1: reset held with btn_in high
        step(1, 1, 3);
        // 2: clean press. E1 is the edge after this negedge.
        step(0, 0, 6);
        @(negedge clk);
        btn_in = 1; rst = 0;
        t0 = cyc;
        step(1, 0, 9);
        chk("press_latency", last_rise_cyc, t0 + SYNC_STAGES + STABLE_CYCLES);
        step(0, 0, 10);
        // 3: bounce reject (3 high, 1 low, 3 high)
        r0 = rise_cnt;
        step(1, 0, 3); step(0, 0, 1); step(1, 0, 3); step(0, 0, 10);
        chk("bounce_no_rise", rise_cnt - r0, 0);
        // 4: bouncy press then release
        r0 = rise_cnt; f0 = fall_cnt;
        step(1, 0, 1); step(0, 0, 1); step(1, 0, 1); step(0, 0, 1);
        step(1, 0, 8); step(0, 0, 8); step(0, 0, 4);
        chk("bouncy_rises", rise_cnt - r0, 1);
        chk("bouncy_falls", fall_cnt - f0, 1);
        // 5: reset sampled at edge 4 of a press. btn_in stays high through release.
        r0 = rise_cnt;
        step(1, 0, 3);
        step(1, 1, 1);
        @(negedge clk);
        btn_in = 1; rst = 0;
        t0 = cyc;
        step(1, 0, 9);
        chk("midreset_one_rise", rise_cnt - r0, 1);
        chk("midreset_latency", last_rise_cyc, t0 + SYNC_STAGES + STABLE_CYCLES);
        step(0, 0, 10);
        // 6: counter hookup with five clean presses
        step(0, 1, 2);
        step(0, 0, 3);
        for (int p = 0; p < 5; p++) begin
            step(1, 0, 10);
            step(0, 0, 10);
        end
        chk("counter2", int'(cnt2), 1);
        // Random bouncy stimulus with occasional resets
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 int'($urandom_range(1, 7)));
        end
        step(0, 0, 12);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
